// File: rtl/dec2bin_accum.sv
// -----------------------------------------------------------------------------
// dec2bin_accum
//
// Sequential decimal-to-binary converter. BCD digits arrive most significant
// first over a valid/ready handshake and are folded into an accumulator as
// acc = acc*10 + digit. The digit flagged with in_last closes the number. The
// unsigned binary result is then presented, together with its flags, on a
// valid/ready output handshake.
//
// Parameters
//   W      result width in bits
//   CNT_W  digit-counter width (the counter saturates at 2^CNT_W-1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     a digit is present on in_digit
//   in_ready     the block accepts a digit this cycle (registered)
//   in_digit     BCD digit, most significant digit first
//   in_last      final digit of the number, qualified by in_valid
//   out_valid    result fields are valid (registered)
//   out_ready    the consumer takes the result this cycle
//   out_result   converted value; all-ones on overflow
//   out_ovf      the true value exceeded 2^W-1
//   out_err      at least one digit was greater than 9
//   out_ndigits  number of digits accepted, saturating
// -----------------------------------------------------------------------------
module dec2bin_accum #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_ovf,
  output logic             out_err,
  output logic [CNT_W-1:0] out_ndigits
);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state;
  logic [W-1:0]     acc;
  logic             ovf;
  logic             err;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             bad_digit;
  logic [3:0]       digit_val;
  logic [W+3:0]     prod;
  logic [W-1:0]     acc_next;
  logic             ovf_next;
  logic             err_next;
  logic [CNT_W-1:0] cnt_next;

  // Out-of-range BCD codes contribute zero to the value.
  function automatic logic [3:0] clean_digit(input logic [3:0] d);
    if (d > 4'd9) begin
      clean_digit = 4'd0;
    end else begin
      clean_digit = d;
    end
  endfunction

  // acc*10 + d built from shifts. W+4 bits holds the worst case
  // (2^W-1)*10 + 9 < 2^(W+4), so the top nibble reveals any overflow.
  function automatic logic [W+3:0] mul10_add(input logic [W-1:0] a,
                                             input logic [3:0]   d);
    logic [W+3:0] wide;
    wide      = {4'd0, a};
    mul10_add = (wide << 3) + (wide << 1) + {{W{1'b0}}, d};
  endfunction

  // Next-state datapath for one accepted digit.
  always_comb begin
    accept    = in_valid & in_ready;
    bad_digit = (in_digit > 4'd9);
    digit_val = clean_digit(in_digit);
    prod      = mul10_add(acc, digit_val);
    // Overflow is sticky. Once it is set the accumulator stays pinned at
    // all-ones whatever digits follow.
    ovf_next  = ovf | (prod[W+3:W] != 4'd0);
    if (ovf_next) begin
      acc_next = {W{1'b1}};
    end else begin
      acc_next = prod[W-1:0];
    end
    err_next  = err | bad_digit;
    if (cnt == {CNT_W{1'b1}}) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM, accumulator and registered output fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACC;
      acc         <= {W{1'b0}};
      ovf         <= 1'b0;
      err         <= 1'b0;
      cnt         <= {CNT_W{1'b0}};
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= {W{1'b0}};
      out_ovf     <= 1'b0;
      out_err     <= 1'b0;
      out_ndigits <= {CNT_W{1'b0}};
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= acc_next;
            ovf <= ovf_next;
            err <= err_next;
            cnt <= cnt_next;
            if (in_last) begin
              // The closing digit is already folded into the published result.
              state       <= DONE;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              out_result  <= acc_next;
              out_ovf     <= ovf_next;
              out_err     <= err_next;
              out_ndigits <= cnt_next;
            end else begin
              state <= ACC;
            end
          end else begin
            state <= ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            // The result has been consumed. Start the next number from zero.
            // in_ready only rises on the following cycle, so a digit cannot
            // pass through in the same cycle.
            state     <= ACC;
            acc       <= {W{1'b0}};
            ovf       <= 1'b0;
            err       <= 1'b0;
            cnt       <= {CNT_W{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state     <= ACC;
          acc       <= {W{1'b0}};
          ovf       <= 1'b0;
          err       <= 1'b0;
          cnt       <= {CNT_W{1'b0}};
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dec2bin_accum.md
Name: dec2bin_accum

Overview:
- Sequential decimal-to-binary converter: the inverse direction of the combinational divide-by-10 unit.
- Accepts a stream of BCD digits, most significant first, over a valid/ready handshake.
- Accumulates acc = acc*10 + digit and emits the unsigned binary result with overflow/error flags on a valid/ready output handshake.
- Used by the FPU text-I/O path to parse decimal operands.

Parameters:
- W, 32, result width in bits.
- CNT_W, 6, digit-counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  digit present on in_digit.
- in_ready  output  1  block can accept a digit this cycle.
- in_digit  input  4  BCD digit, MSD first.
- in_last  input  1  marks the final digit of the number; qualified by in_valid.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer takes the result this cycle.
- out_result  output  W  converted value; all-ones when out_ovf=1.
- out_ovf  output  1  true value exceeded 2^W-1.
- out_err  output  1  at least one digit was >9.
- out_ndigits  output  CNT_W  number of digits accepted, saturating.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=ACC, acc=0, ovf=0, err=0, cnt=0, out_valid=0, out_result=0, out_ovf=0, out_err=0, out_ndigits=0. in_ready=1 from the first cycle after reset.
- rst has priority over every other event. Reset mid-number or during DONE discards all state; no partial result is ever emitted.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Digit accept = in_valid & in_ready, sampled at a rising edge.
- On accept, with d = (in_digit>9) ? 0 : in_digit:
  - next = (acc<<3) + (acc<<1) + d, computed at W+4 bits.
  - If next[W+3:W]!=0 or ovf already set: ovf<=1 and acc is held at all-ones (saturate). Otherwise acc<=next[W-1:0].
  - in_digit>9 sets err (sticky); that digit contributes 0 but is still counted.
  - cnt<=cnt+1, saturating at 2^CNT_W-1.
- Accept with in_last=1: the result is computed from the same digit. The outputs are registered with that edge's updated acc/ovf/err/cnt, and state goes to DONE. out_valid is high in the cycle immediately after the accepting edge (latency 1).
- DONE: all outputs are held stable while out_ready=0. in_valid is ignored (in_ready=0).
- Output handshake out_valid & out_ready at an edge clears acc, ovf, err and cnt, and state goes to ACC. in_ready=1 the next cycle; there is no same-cycle pass-through of a new digit.
- out_ready while out_valid=0 has no effect. in_last without in_valid has no effect.
- Leading zeros are legal and do not cause overflow; only the numeric value matters.
- The single-digit number (first digit carries in_last) is legal.
- Once saturated, out_result=all-ones regardless of subsequent digits.
- No combinational path from any input to any output: in_ready and out_* are pure functions of registered state.

Test Plan:
- Digits 4,0,9,6 (last on 6), out_ready=1 -> out_valid one cycle after the "6" edge, out_result=4096, ovf=0, err=0, ndigits=4. in_ready=1 the following cycle.
- Digits 4,2,9,4,9,6,7,2,9,5 -> out_result=0xFFFFFFFF, ovf=0, ndigits=10. Then 4,2,9,4,9,6,7,2,9,6 -> out_result=0xFFFFFFFF, ovf=1. Then 99999999999 (11 digits) -> ovf=1.
- Digits 0 x11 then 1,2 (13 digits) -> out_result=12, ovf=0, ndigits=13. Single digit 7 with last -> out_result=7, ndigits=1.
- Digits 3,0xA,5 -> out_result=305, err=1, ovf=0, ndigits=3. The next number 8 -> err=0 (flags cleared).
- Backpressure: result 4096 with out_ready=0 for 3 cycles -> outputs stable, in_ready=0, extra in_valid pulses ignored. out_ready=1 -> handshake, and the next number 1,5 yields 15.
- rst=1 after digits 1,2,3 (no last) -> all outputs 0 next cycle. Digits 5,last -> out_result=5, ndigits=1. Also rst asserted during DONE -> out_valid=0 the next cycle.
